// File: rtl/vga_bounce_box.sv
// Video source stage: a solid square bouncing around a black active area.
// Optional one-pixel white border around the active area: VGA_BOUNCE_BORDER_EN.
module vga_bounce_box #(
    parameter int c_VIDEO_WIDTH = 3,
    parameter int c_ACTIVE_COLS = 640,
    parameter int c_ACTIVE_ROWS = 480,
    parameter int c_BOX_SIZE    = 32,
    parameter int c_STEP        = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset,
    input  logic [9:0]               i_Col_Count,
    input  logic [9:0]               i_Row_Count,
    input  logic                     i_Pause,
    input  logic                     i_Color_Next,
    output logic [9:0]               o_Col_Count,
    output logic [9:0]               o_Row_Count,
    output logic [c_VIDEO_WIDTH-1:0] o_Red_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Grn_Video,
    output logic [c_VIDEO_WIDTH-1:0] o_Blu_Video,
    output logic                     o_Frame_Tick
);

    localparam logic [10:0] c_COLS11 = 11'(c_ACTIVE_COLS);
    localparam logic [10:0] c_ROWS11 = 11'(c_ACTIVE_ROWS);
    localparam logic [10:0] c_BOX11  = 11'(c_BOX_SIZE);
    localparam logic [10:0] c_STEP11 = 11'(c_STEP);
    localparam logic [10:0] c_X_MAX  = 11'(c_ACTIVE_COLS - c_BOX_SIZE);
    localparam logic [10:0] c_Y_MAX  = 11'(c_ACTIVE_ROWS - c_BOX_SIZE);
    localparam logic [9:0]  c_X_RST  = 10'((c_ACTIVE_COLS - c_BOX_SIZE) / 2);
    localparam logic [9:0]  c_Y_RST  = 10'((c_ACTIVE_ROWS - c_BOX_SIZE) / 2);

    typedef enum logic [1:0] {
        S_WAIT,
        S_UPD_X,
        S_UPD_Y
    } state_t;

    state_t                   state_q;
    logic [9:0]               x_q, y_q, x_d, y_d;
    logic                     dx_q, dy_q, dx_d, dy_d;
    logic [2:0]               color_q, color_d;
    logic                     pend_q, btn_q, tick_q;
    logic [9:0]               col_q, row_q;
    logic [c_VIDEO_WIDTH-1:0] red_q, grn_q, blu_q;
    logic [c_VIDEO_WIDTH-1:0] red_d, grn_d, blu_d;
    logic                     frame_evt, rise, in_box, border;
    logic [10:0]              col11, row11;

    // Returns {new_dir, new_pos}; 11-bit math so the edge tests never wrap.
    function automatic logic [10:0] axis_next(
        input logic [9:0]  pos,
        input logic        dir,
        input logic [10:0] pmax
    );
        logic [10:0] p;
        logic [10:0] sum;
        logic [10:0] diff;
        p    = {1'b0, pos};
        sum  = p + c_STEP11;
        diff = p - c_STEP11;
        if (dir) begin
            if (sum > pmax) return {1'b0, pmax[9:0]};
            return {1'b1, sum[9:0]};
        end
        if (p < c_STEP11) return {1'b1, 10'd0};
        return {1'b0, diff[9:0]};
    endfunction

    always_comb begin
        {dx_d, x_d} = axis_next(x_q, dx_q, c_X_MAX);
        {dy_d, y_d} = axis_next(y_q, dy_q, c_Y_MAX);
        color_d     = (color_q == 3'd7) ? 3'd1 : color_q + 3'd1;
        frame_evt   = (i_Col_Count == 10'd0) && ({1'b0, i_Row_Count} == c_ROWS11);
        rise        = i_Color_Next & ~btn_q;
    end

    always_comb begin
        col11  = {1'b0, i_Col_Count};
        row11  = {1'b0, i_Row_Count};
        in_box = (col11 >= {1'b0, x_q}) && (col11 < {1'b0, x_q} + c_BOX11) &&
                 (row11 >= {1'b0, y_q}) && (row11 < {1'b0, y_q} + c_BOX11);
`ifdef VGA_BOUNCE_BORDER_EN
        border = (col11 < c_COLS11) && (row11 < c_ROWS11) &&
                 ((col11 == 11'd0) || (col11 == c_COLS11 - 11'd1) ||
                  (row11 == 11'd0) || (row11 == c_ROWS11 - 11'd1));
`else
        border = 1'b0;
`endif
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        if (in_box) begin
            red_d = {c_VIDEO_WIDTH{color_q[0]}};
            grn_d = {c_VIDEO_WIDTH{color_q[1]}};
            blu_d = {c_VIDEO_WIDTH{color_q[2]}};
        end else if (border) begin
            red_d = '1;
            grn_d = '1;
            blu_d = '1;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q <= S_WAIT;
            x_q     <= c_X_RST;
            y_q     <= c_Y_RST;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            color_q <= 3'd1;
            pend_q  <= 1'b0;
            btn_q   <= 1'b0;
            tick_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            red_q   <= '0;
            grn_q   <= '0;
            blu_q   <= '0;
        end else begin
            col_q  <= i_Col_Count;
            row_q  <= i_Row_Count;
            red_q  <= red_d;
            grn_q  <= grn_d;
            blu_q  <= blu_d;
            btn_q  <= i_Color_Next;
            tick_q <= 1'b0;
            pend_q <= pend_q | rise;
            case (state_q)
                S_WAIT: begin
                    if (frame_evt) begin
                        state_q <= S_UPD_X;
                        tick_q  <= 1'b1;
                    end
                end
                S_UPD_X: begin
                    state_q <= S_UPD_Y;
                    if (!i_Pause) begin
                        x_q  <= x_d;
                        dx_q <= dx_d;
                    end
                end
                S_UPD_Y: begin
                    state_q <= S_WAIT;
                    if (!i_Pause) begin
                        y_q  <= y_d;
                        dy_q <= dy_d;
                    end
                    // A fresh edge on the clearing cycle stays queued.
                    if (pend_q) begin
                        color_q <= color_d;
                        pend_q  <= rise;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign o_Col_Count  = col_q;
    assign o_Row_Count  = row_q;
    assign o_Red_Video  = red_q;
    assign o_Grn_Video  = grn_q;
    assign o_Blu_Video  = blu_q;
    assign o_Frame_Tick = tick_q;

endmodule

// File: tb/tb_vga_bounce_box.sv
// Bench for vga_bounce_box: two instances (step 2 and step 3) checked
// against a behavioural bouncing-box model using bench-driven counts.
module tb_vga_bounce_box;

    localparam int COLS = 640;
    localparam int ROWS = 480;
    localparam int BOX  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] col, row;
    logic       pause, btn;

    logic [9:0] oc0, or0, oc1, or1;
    logic [2:0] r0, g0, b0, r1, g1, b1;
    logic       t0, t1;

    int vectors = 0;
    int miscompares = 0;

    int mx[2], my[2], mdx[2], mdy[2];
    int stp[2] = '{2, 3};
    int mcol, mpend, mprev;

    always #5 clk = ~clk;

    vga_bounce_box u_dut0 (
        .i_Clk(clk), .i_Reset(rst),
        .i_Col_Count(col), .i_Row_Count(row),
        .i_Pause(pause), .i_Color_Next(btn),
        .o_Col_Count(oc0), .o_Row_Count(or0),
        .o_Red_Video(r0), .o_Grn_Video(g0), .o_Blu_Video(b0),
        .o_Frame_Tick(t0)
    );

    vga_bounce_box #(.c_STEP(3)) u_dut1 (
        .i_Clk(clk), .i_Reset(rst),
        .i_Col_Count(col), .i_Row_Count(row),
        .i_Pause(pause), .i_Color_Next(btn),
        .o_Col_Count(oc1), .o_Row_Count(or1),
        .o_Red_Video(r1), .o_Grn_Video(g1), .o_Blu_Video(b1),
        .o_Frame_Tick(t1)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k]  = (COLS - BOX) / 2;
            my[k]  = (ROWS - BOX) / 2;
            mdx[k] = 1;
            mdy[k] = 1;
        end
        mcol  = 1;
        mpend = 0;
        mprev = 0;
    endtask

    function automatic int axis(input int p, input int d, input int s,
                                input int pmax, output int nd);
        nd = d;
        if (d == 1) begin
            if (p + s > pmax) begin
                nd = 0;
                return pmax;
            end
            return p + s;
        end
        if (p < s) begin
            nd = 1;
            return 0;
        end
        return p - s;
    endfunction

    function automatic logic [8:0] pix(input int c, input int r,
                                       input int x, input int y, input int cl);
        logic [8:0] v;
        v = 9'd0;
        if (c >= COLS || r >= ROWS) return v;
        if (c >= x && c < x + BOX && r >= y && r < y + BOX) begin
            v[8:6] = cl[0] ? 3'd7 : 3'd0;
            v[5:3] = cl[1] ? 3'd7 : 3'd0;
            v[2:0] = cl[2] ? 3'd7 : 3'd0;
            return v;
        end
`ifdef VGA_BOUNCE_BORDER_EN
        if (c == 0 || c == COLS - 1 || r == 0 || r == ROWS - 1) return 9'h1FF;
`endif
        return v;
    endfunction

    // ph: 0 plain, 1 frame event, 2 X-update cycle, 3 Y-update cycle
    task automatic apply(input int c, input int r, input int ph);
        logic [8:0] e0, e1;
        int rise, nd;
        c = c & 1023;
        r = r & 1023;
        if (ph != 1 && c == 0 && r == ROWS) c = 1;
        col = c[9:0];
        row = r[9:0];
        e0 = pix(c, r, mx[0], my[0], mcol);
        e1 = pix(c, r, mx[1], my[1], mcol);
        rise = (btn && !mprev) ? 1 : 0;
        mprev = btn ? 1 : 0;
        @(posedge clk);
        #1;
        vectors++;
        if ({oc0, or0, oc1, or1} !== {c[9:0], r[9:0], c[9:0], r[9:0]}) begin
            miscompares++;
            $display("FAIL counts got=%0d,%0d/%0d,%0d exp=%0d,%0d",
                     oc0, or0, oc1, or1, c, r);
        end
        vectors++;
        if ({t0, t1} !== ((ph == 1) ? 2'b11 : 2'b00)) begin
            miscompares++;
            $display("FAIL tick ph=%0d got=%b%b exp=%0d", ph, t0, t1, ph == 1);
        end
        vectors++;
        if ({r0, g0, b0} !== e0) begin
            miscompares++;
            $display("FAIL pix0 col=%0d row=%0d got=%h exp=%h box=%0d,%0d",
                     c, r, {r0, g0, b0}, e0, mx[0], my[0]);
        end
        vectors++;
        if ({r1, g1, b1} !== e1) begin
            miscompares++;
            $display("FAIL pix1 col=%0d row=%0d got=%h exp=%h box=%0d,%0d",
                     c, r, {r1, g1, b1}, e1, mx[1], my[1]);
        end
        for (int k = 0; k < 2; k++) begin
            if (ph == 2 && !pause) mx[k] = axis(mx[k], mdx[k], stp[k], COLS - BOX, mdx[k]);
            if (ph == 3 && !pause) my[k] = axis(my[k], mdy[k], stp[k], ROWS - BOX, mdy[k]);
        end
        if (ph == 3) begin
            if (mpend != 0) mcol = (mcol == 7) ? 1 : mcol + 1;
            if (mpend != 0 || rise != 0) mpend = rise;
        end else begin
            mpend = mpend | rise;
        end
        nd = 0;
    endtask

    task automatic frame(input bit late_press = 1'b0);
        apply(0, ROWS, 1);
        apply(1, ROWS, 2);
        if (late_press) btn = 1'b1;
        apply(2, ROWS, 3);
        btn = 1'b0;
        apply(3, ROWS, 0);
    endtask

    task automatic press();
        btn = 1'b1;
        apply(5, 490, 0);
        btn = 1'b0;
        apply(6, 490, 0);
    endtask

    task automatic probe_box();
        for (int k = 0; k < 2; k++) begin
            apply(mx[k], my[k], 0);
            apply(mx[k] - 1, my[k], 0);
            apply(mx[k] + BOX - 1, my[k] + BOX - 1, 0);
            apply(mx[k] + BOX, my[k] + BOX - 1, 0);
            apply(mx[k] + BOX - 1, my[k] + BOX, 0);
            apply(mx[k] + 16, my[k] - 1, 0);
        end
        apply(0, 100, 0);
        apply($urandom_range(0, 799), $urandom_range(0, 524), 0);
        apply($urandom_range(0, 799), $urandom_range(0, 524), 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        col = '0;
        row = '0;
        pause = 1'b0;
        btn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({oc0, or0, r0, g0, b0, t0, oc1, or1, r1, g1, b1, t1} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {oc0, or0, r0, g0, b0, t0, oc1, or1, r1, g1, b1, t1});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_defaults();
        apply(304, 224, 0);
        apply(303, 224, 0);
        apply(335, 255, 0);
        apply(336, 255, 0);
        apply(304, 223, 0);
        apply(304, 256, 0);
        apply(320, 240, 0);
        apply(0, 100, 0);
        apply(639, 479, 0);
        apply(700, 100, 0);
    endtask

    task automatic test_five_frames();
        repeat (5) frame();
        apply(314, 234, 0);
        apply(313, 234, 0);
        apply(345, 265, 0);
        apply(346, 265, 0);
        probe_box();
    endtask

    task automatic test_pause();
        pause = 1'b1;
        press();
        repeat (3) frame();
        pause = 1'b0;
        probe_box();
    endtask

    task automatic test_colour();
        press();
        press();
        frame();
        probe_box();
        for (int i = 0; i < 8 && mcol != 7; i++) begin
            press();
            frame();
        end
        probe_box();
        press();
        frame();
        probe_box();
        press();
        frame(1'b1);
        frame();
        probe_box();
    endtask

    task automatic test_bounce_random();
        for (int i = 0; i < 500; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) press();
            frame($urandom_range(0, 9) == 0);
            pause = 1'b0;
            if (i % 4 == 0 || mx[0] < 4 || mx[0] > 604 || mx[1] < 4 || mx[1] > 603)
                probe_box();
        end
    endtask

    task automatic test_back_to_back();
        apply(0, ROWS, 1);
        apply(1, ROWS, 2);
        apply(2, ROWS, 3);
        apply(0, ROWS, 1);
        apply(1, ROWS, 2);
        apply(2, ROWS, 3);
        probe_box();
    endtask

    task automatic test_mid_reset();
        press();
        apply(0, ROWS, 1);
        rst = 1'b1;
        #1;
        vectors++;
        if ({r0, g0, b0, t0, oc0, r1, g1, b1, t1} !== '0) begin
            miscompares++;
            $display("FAIL async_reset got=%h exp=0", {r0, g0, b0, t0, oc0, r1, g1, b1, t1});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        probe_box();
        frame();
        probe_box();
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_five_frames();
        test_pause();
        test_colour();
        test_bounce_random();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_bounce_box.md
# vga_bounce_box

Video source stage for the VGA pipeline. Consumes the free-running column/row counts from the VGA counter and produces registered per-pixel RGB for the sync/porch stage. The picture is a solid square on a black background that moves one step per frame and bounces off the active-area edges. Colour changes on a button press, and motion can be paused.

## Interface
Parameters:
- c_VIDEO_WIDTH, 3, bits per colour channel
- c_ACTIVE_COLS, 640, visible columns
- c_ACTIVE_ROWS, 480, visible rows
- c_BOX_SIZE, 32, square side in pixels; must be smaller than both active dimensions
- c_STEP, 2, pixels moved per frame on each axis; 1 ≤ c_STEP < c_BOX_SIZE

Ports:
- i_Clk  in  1  pixel clock, single clock domain
- i_Reset  in  1  asynchronous, active-high reset
- i_Col_Count  in  10  current column from VGA counter
- i_Row_Count  in  10  current row from VGA counter
- i_Pause  in  1  level; high freezes position
- i_Color_Next  in  1  level, synchronous, debounced button; each rising edge requests the next colour
- o_Col_Count  out  10  i_Col_Count delayed 1 cycle, aligned with video
- o_Row_Count  out  10  i_Row_Count delayed 1 cycle, aligned with video
- o_Red_Video / o_Grn_Video / o_Blu_Video  out  c_VIDEO_WIDTH each  pixel colour
- o_Frame_Tick  out  1  one-cycle pulse at start of vertical blanking

## Operation
- Box state:
  - X position, 10 bits, range 0..c_ACTIVE_COLS-c_BOX_SIZE.
  - Y position, 10 bits, range 0..c_ACTIVE_ROWS-c_BOX_SIZE.
  - Direction bits dx and dy: 1 = increasing.
  - 3-bit colour index, range 1..7.
- Reset values:
  - X=(c_ACTIVE_COLS-c_BOX_SIZE)/2 (304), Y=(c_ACTIVE_ROWS-c_BOX_SIZE)/2 (224).
  - dx=1, dy=1, colour=1, pending colour request=0.
  - All outputs 0. FSM in S_WAIT.
- Frame event: a cycle where i_Col_Count==0 and i_Row_Count==c_ACTIVE_ROWS.
- FSM:
  - S_WAIT → S_UPD_X on frame event. o_Frame_Tick is high in the following cycle.
  - S_UPD_X → S_UPD_Y. Update X, dx.
  - S_UPD_Y → S_WAIT. Update Y, dy, apply colour.
- Axis update (X shown; Y is identical against rows). Skipped entirely if i_Pause is high in that cycle; direction is unchanged.
  - dx=1: if X+c_STEP > c_ACTIVE_COLS-c_BOX_SIZE, set X=c_ACTIVE_COLS-c_BOX_SIZE and dx=0; else X=X+c_STEP.
  - dx=0: if X < c_STEP, set X=0 and dx=1; else X=X-c_STEP.
  - Comparisons use 11-bit unsigned arithmetic; no wrap-around.
- Colour:
  - i_Color_Next is registered, and a rising edge sets the pending flag.
  - In S_UPD_Y, a pending request advances the index (7 wraps to 1) and clears the flag. This happens even when paused.
  - An edge in the same cycle as the clear leaves the flag set for the next frame.
- Render, registered:
  - Inside the box (X ≤ col < X+c_BOX_SIZE and Y ≤ row < Y+c_BOX_SIZE): channel = all ones if colour bit set, else 0. Bit0 = red, bit1 = green, bit2 = blue.
  - Inside the active area but not the box: 0.
  - Outside the active area: 0.

## Timing
- Video latency: 1 cycle from input counts to RGB. o_Col_Count/o_Row_Count are delayed identically.
- Position and colour change only in blanking, at most 3 cycles after the frame event. A visible frame always shows a single consistent box.
- o_Frame_Tick: exactly one cycle per frame, 1 cycle after the frame event.
- Reset asserted mid-update: all state returns immediately to reset values; the FSM returns to S_WAIT.

## Configuration
- VGA_BOUNCE_BORDER_EN
  - Defined: active-area pixels with col==0, col==c_ACTIVE_COLS-1, row==0 or row==c_ACTIVE_ROWS-1 output all ones on all channels. The box overrides the border where they overlap.
  - Undefined: no border; the background is entirely black.

## Test plan
- Reset, one frame, defaults → box pixels at cols 304..335, rows 224..255 are red (7,0,0); elsewhere 0; RGB lags counts by 1 cycle.
- Run 5 frames, dx=dy=1, c_STEP=2 → X=314, Y=234; o_Frame_Tick pulses once per frame.
- Force X=607 moving right, one update → X=608 (the maximum), dx=0; next update → X=606.
- i_Pause high across 3 frame events → X/Y unchanged; a button press during pause still changes colour red → green (0,7,0) after the next update.
- Two presses within one frame → colour advances by one only; press at colour 7 → colour 1.
- With VGA_BOUNCE_BORDER_EN: pixel (0,100) = (7,7,7); box moved to X=0 → box colour at col 0. Without the macro: pixel (0,100) = 0.
